// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter8_if import arb_pkg::*; ();
  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_vld;
  logic             timeout;

  modport master (output req, done, input gnt, gnt_id, gnt_vld, timeout);
  modport slave  (input req, done, output gnt, gnt_id, gnt_vld, timeout);
endinterface

// File: rtl/rr_arbiter8_prio_enc.sv
// Rotating first-set-bit encoder: lowest set bit of req scanning from ptr upward, mod 8.
module rr_prio_enc8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] sel,
  output logic       any
);
  logic [14:0] dbl;
  logic [7:0]  rot;
  logic [2:0]  idx;

  // Doubling the vector turns the rotate-right into a plain indexed slice.
  assign dbl = {req[6:0], req};
  assign rot = dbl[ptr +: 8];
  assign any = |req;

  always_comb begin
    idx = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (rot[i-1]) idx = 3'(i - 1);
    end
  end

  assign sel = idx + ptr;
endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter holding each grant until done or withdraw.
// Optional forced release after MAX_HOLD busy cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8 import arb_pkg::*; #(
  parameter int MAX_HOLD = 16
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter8_if.slave bus
);
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD out of range 2..255");
  end

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] gnt_q;
  logic [ID_W-1:0]  gnt_id_q;
  logic             gnt_vld_q;
  logic             timeout_q;
  logic [ID_W-1:0]  sel;
  logic             any;
  logic             release_c;

  rr_prio_enc8 u_enc (
    .req (bus.req),
    .ptr (ptr),
    .sel (sel),
    .any (any)
  );

  assign release_c = bus.done | ~bus.req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
      timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          timeout_q <= 1'b0;
          if (any) begin
            gnt_q     <= N_REQ'(1) << sel;
            gnt_id_q  <= sel;
            gnt_vld_q <= 1'b1;
            state     <= ST_BUSY;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        ST_BUSY: begin
`ifdef ARB_TIMEOUT_EN
          // A normal release wins over the forced one, so timeout only fires without it.
          if (release_c || hold_cnt == HOLD_LAST) begin
            timeout_q <= ~release_c;
`else
          if (release_c) begin
`endif
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            gnt_vld_q <= 1'b0;
            ptr       <= gnt_id_q + 1'b1;
            state     <= ST_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.gnt_vld = gnt_vld_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
  logic unused_timeout;
  assign unused_timeout = timeout_q;
`endif
endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8 (covers both ARB_TIMEOUT_EN builds).
module tb_rr_arbiter8;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [2:0] id);
    chk({tag, "_vld"}, {7'd0, bus.gnt_vld}, 8'h01);
    chk({tag, "_id"},  {5'd0, bus.gnt_id},  {5'd0, id});
    chk({tag, "_gnt"}, bus.gnt,             8'h01 << id);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, {7'd0, bus.gnt_vld}, 8'h00);
    chk({tag, "_gnt"}, bus.gnt,             8'h00);
  endtask

  initial begin
    rst = 1'b1; bus.req = 8'hFF; bus.done = 1'b0;
    tick(); tick();
    chk_idle("reset");
    chk("reset_id", {5'd0, bus.gnt_id}, 8'h00);
    chk("reset_to", {7'd0, bus.timeout}, 8'h00);

    rst = 1'b0; tick();
    chk_grant("first", 3'd0);
    bus.done = 1'b1; tick();
    chk_idle("first_rel");
    bus.done = 1'b0; bus.req = 8'h00; tick();
    chk_idle("empty");

    // Rotation: ptr=1, requests on 2 and 5
    bus.req = 8'b0010_0100; tick();
    chk_grant("rot_a", 3'd2);
    bus.done = 1'b1; tick(); chk_idle("rot_a_rel");
    bus.done = 1'b0; tick(); chk_grant("rot_b", 3'd5);
    bus.done = 1'b1; tick(); chk_idle("rot_b_rel");
    bus.done = 1'b0; tick(); chk_grant("rot_c", 3'd2);
    bus.done = 1'b1; tick(); chk_idle("rot_c_rel");
    bus.done = 1'b0; tick(); chk_grant("rot_d", 3'd5);
    bus.done = 1'b1; tick();
    bus.done = 1'b0; bus.req = 8'h00; tick();

    // Wrap: grant 6 leaves ptr=7, then 0 beats 6
    bus.req = 8'b0100_0000; tick(); chk_grant("wrap_6", 3'd6);
    bus.done = 1'b1; tick();
    bus.done = 1'b0; bus.req = 8'b0100_0001; tick();
    chk_grant("wrap_0", 3'd0);
    bus.done = 1'b1; tick();
    bus.done = 1'b0; tick();
    chk_grant("wrap_ptr1", 3'd6);
    bus.done = 1'b1; tick();
    bus.done = 1'b0; bus.req = 8'h00; tick();

    // Withdraw from 3, done in IDLE ignored, ptr then 4
    bus.req = 8'b0000_1000; tick(); chk_grant("wd", 3'd3);
    bus.req = 8'h00; tick(); chk_idle("wd_rel");
    bus.done = 1'b1; tick(); chk_idle("wd_idle_done");
    bus.done = 1'b0; bus.req = 8'b0001_1000; tick();
    chk_grant("wd_ptr4", 3'd4);
    bus.req = 8'b1001_1000; tick(); chk_grant("busy_hold", 3'd4);

    // Done plus withdraw together count once
    bus.req = 8'h00; bus.done = 1'b1; tick(); chk_idle("both_rel");
    bus.done = 1'b0; bus.req = 8'b0010_0001; tick();
    chk_grant("both_ptr5", 3'd5);

    // Mid-grant reset, then ptr back at 0
    bus.req = 8'h10; rst = 1'b1; tick();
    chk_idle("mid_rst");
    rst = 1'b0; tick(); chk_grant("post_rst", 3'd4);
    bus.done = 1'b1; tick();
    bus.done = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; bus.req = 8'h18; tick();
    chk_grant("rst_ptr0", 3'd3);
    bus.done = 1'b1; tick();
    bus.done = 1'b0; bus.req = 8'h00; rst = 1'b1; tick();
    rst = 1'b0;

    // Long hold on requester 1
    bus.req = 8'h02; tick(); chk_grant("hold", 3'd1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_grant("hold_busy", 3'd1);
      chk("hold_to", {7'd0, bus.timeout}, 8'h00);
    end
    tick();
    chk_idle("to_rel");
    chk("to_pulse", {7'd0, bus.timeout}, 8'h01);
    bus.req = 8'h06; tick();
    chk("to_clear", {7'd0, bus.timeout}, 8'h00);
    chk_grant("to_ptr2", 3'd2);
    tick(); tick(); tick();
    chk_grant("prec_busy", 3'd2);
    bus.done = 1'b1; tick();
    chk_idle("prec_rel");
    chk("prec_to", {7'd0, bus.timeout}, 8'h00);
    bus.done = 1'b0;
`else
    for (int i = 0; i < 22; i++) begin
      tick();
      chk_grant("hold_busy", 3'd1);
      chk("hold_to", {7'd0, bus.timeout}, 8'h00);
    end
    bus.done = 1'b1; tick();
    chk_idle("hold_rel");
    bus.done = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
